// File: rtl/multiplicador_nbits_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package multiplicador_pkg;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_RUN  = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_t;

  // Iteration counter must hold WIDTH-1 for any WIDTH in 2..32.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/multiplicador_nbits_if.sv
// Operand/handshake/result bundle between a controller (master) and the multiplier (slave).
interface multiplicador_nbits_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   A_i;
  logic [WIDTH-1:0]   B_i;
  logic               signed_i;
  logic               start_i;
  logic               ready_o;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] Y_o;

  modport master (
    output A_i, B_i, signed_i, start_i,
    input  ready_o, busy_o, done_o, Y_o
  );

  modport slave (
    input  A_i, B_i, signed_i, start_i,
    output ready_o, busy_o, done_o, Y_o
  );
endinterface

// File: rtl/multiplicador_nbits_operand_cond.sv
// Splits an operand into unsigned magnitude and sign; |-2^(W-1)| still fits in W unsigned bits.
module mult_operand_cond #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] operand_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             sign_o
);

  // Negate only signed operands whose top bit is set.
  always_comb begin
    sign_o = signed_i & operand_i[WIDTH-1];
    if (sign_o) begin
      mag_o = (~operand_i) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag_o = operand_i;
    end
  end

endmodule

// File: rtl/multiplicador_nbits.sv
// Sequential shift-add multiplier: one multiplier bit per cycle on magnitudes, sign applied at the end.
module multiplicador_nbits
  import multiplicador_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_TERM = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  multiplicador_nbits_if.slave bus
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  mult_state_t          state_q;
  logic [2*WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   y_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;

  logic [WIDTH-1:0]     mag_a_s;
  logic [WIDTH-1:0]     mag_b_s;
  logic                 sign_a_s;
  logic                 sign_b_s;
  logic [2*WIDTH-1:0]   sum_d;
  logic [2*WIDTH-1:0]   y_d;
  logic                 finish_d;

  mult_operand_cond #(.WIDTH(WIDTH)) u_cond_a (
    .operand_i (bus.A_i),
    .signed_i  (bus.signed_i),
    .mag_o     (mag_a_s),
    .sign_o    (sign_a_s)
  );

  mult_operand_cond #(.WIDTH(WIDTH)) u_cond_b (
    .operand_i (bus.B_i),
    .signed_i  (bus.signed_i),
    .mag_o     (mag_b_s),
    .sign_o    (sign_b_s)
  );

  // Per-iteration accumulate, termination test and signed result.
  always_comb begin
    sum_d    = acc_q;
    finish_d = 1'b0;
    y_d      = acc_q;
    if (b_q[0]) begin
      sum_d = acc_q + a_q;
    end else begin
      sum_d = acc_q;
    end
    if ((cnt_q == CNT_LAST) || (EARLY_TERM && (b_q == '0))) begin
      finish_d = 1'b1;
    end else begin
      finish_d = 1'b0;
    end
    if (neg_q) begin
      y_d = '0 - sum_d;
    end else begin
      y_d = sum_d;
    end
  end

  // Control FSM and datapath registers; all handshake outputs are registered here.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= MULT_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      y_q     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        MULT_IDLE, MULT_DONE: begin
          if (bus.start_i) begin
            a_q     <= {{WIDTH{1'b0}}, mag_a_s};
            b_q     <= mag_b_s;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= sign_a_s ^ sign_b_s;
            state_q <= MULT_RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        MULT_RUN: begin
          acc_q <= sum_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CNT_ONE;
          if (finish_d) begin
            y_q     <= y_d;
            state_q <= MULT_DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= MULT_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.Y_o     = y_q;

endmodule
